pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter STAGE, default 1, meaning the index of the driving stage in the stall vector.
REQ-002 SHALL have parameter STALL_W, default 6, meaning the stall vector width; STAGE+1 < STALL_W is required.
REQ-003 SHALL have parameter LANES, default 1, meaning the number of parallel instruction slots.
REQ-004 SHALL have parameter ADDR_W, default 32, meaning the PC width per lane.
REQ-005 SHALL have parameter DATA_W, default 32, meaning the instruction width per lane.
REQ-006 SHALL have parameter CNT_W, default 32, meaning the performance counter width.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 stall  input  STALL_W  per-stage stop request; 1 = stop.
REQ-010 flush  input  1  pipeline flush (branch/exception redirect).
REQ-011 in_valid  input  LANES  per-lane valid from the upstream stage.
REQ-012 in_pc  input  LANES*ADDR_W  upstream PCs; lane 0 in the LSBs.
REQ-013 in_inst  input  LANES*DATA_W  upstream instructions; lane 0 in the LSBs.
REQ-014 out_valid  output  LANES  registered per-lane valid.
REQ-015 out_pc  output  LANES*ADDR_W  registered PCs.
REQ-016 out_inst  output  LANES*DATA_W  registered instructions.
REQ-017 bubble  output  1  high when a bubble was inserted on the last edge.
REQ-018 perf_stall, perf_bubble, perf_flush  output  CNT_W each  counters; present only with PIPE_PERF_EN.

Function
REQ-019 SHALL define up = stall[STAGE] and dn = stall[STAGE+1].
REQ-020 SHALL apply one action per rising edge, in priority order: rst, flush, bubble (up=1, dn=0), hold (up=1, dn=1), advance (up=0).
REQ-021 On flush, SHALL clear all out_valid bits and drive out_pc and out_inst to 0, regardless of the stall inputs.
REQ-022 On bubble, SHALL clear all out_valid bits and drive out_pc and out_inst to 0.
REQ-023 On hold, SHALL keep all outputs unchanged.
REQ-024 On advance, SHALL load in_valid, in_pc and in_inst, so the latency is one cycle.
REQ-025 On advance, SHALL write 0 to the pc and inst fields of any lane whose in_valid bit is 0.
REQ-026 up=0 with dn=1 is an illegal combination; it SHALL be treated as advance and SHALL raise an assertion in simulation.
REQ-027 bubble SHALL be registered: 1 for exactly the cycle after a bubble action, else 0; flush does not set it.
REQ-028 Lanes SHALL be independent in data and shared in control; no lane reordering or compaction is performed.

Reset
REQ-029 On rst, SHALL drive out_valid, out_pc, out_inst and bubble to 0, and all counters to 0.
REQ-030 rst asserted during a hold SHALL discard the held instruction on that edge.
REQ-031 The first edge after rst deasserts SHALL follow REQ-020 normally.

Configuration
REQ-032 Macro PIPE_PERF_EN SHALL compile the counters in; without it the perf ports and counter logic SHALL be absent.
REQ-033 With PIPE_PERF_EN, perf_stall SHALL increment on each hold edge.
REQ-034 With PIPE_PERF_EN, perf_bubble SHALL increment on each bubble edge.
REQ-035 With PIPE_PERF_EN, perf_flush SHALL increment on each flush edge.
REQ-036 All counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-037 With flush and a stall combination on the same edge, only perf_flush SHALL increment.

Structure
REQ-038 Stall polarity constants (Stop=1, NoStop=0), ZeroWord and the action encoding (ACT_RST, ACT_FLUSH, ACT_BUBBLE, ACT_HOLD, ACT_ADV) SHALL live in the shared define/package file.
REQ-039 Each saturating counter SHALL be one sub-module, sat_counter (CNT_W, inc, clr), instantiated three times under PIPE_PERF_EN.
REQ-040 Per-lane datapath SHALL be a generate loop over LANES.

Verification
REQ-041 rst=1 with in_valid=1, in_pc=0x100, in_inst=0x24010001 -> next edge: out_valid=0, out_pc=0, out_inst=0, bubble=0.
REQ-042 Advance, LANES=2, in_valid=2'b01, in_pc={0x204,0x200} -> out_valid=2'b01, lane0 pc=0x200, lane1 pc=0, lane1 inst=0.
REQ-043 stall=6'b000110 (STAGE=1) for 3 edges with in_pc changing -> outputs frozen at the pre-stall value; perf_stall=3.
REQ-044 stall=6'b000010 -> out_valid=0, out_inst=0, bubble=1 for one cycle; perf_bubble=1.
REQ-045 flush=1 together with stall=6'b000110 -> outputs cleared; perf_flush=1; perf_stall unchanged.
REQ-046 CNT_W=4 with 20 consecutive hold edges -> perf_stall=4'hF, with no wrap.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared stall polarity, zero word and stage action encoding
package pipe_stage_reg_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int ZeroWordW = 256;
  localparam logic [ZeroWordW-1:0] ZeroWord = '0;

  typedef enum logic [2:0] {
    ACT_RST,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_ADV
  } act_e;

  // Priority: reset, flush, then the local/downstream stall pair.
  // up=NoStop always advances, even if downstream is stopped.
  function automatic act_e decode_action(input logic rst, input logic flush,
                                         input logic up, input logic dn);
    if (rst)
      return ACT_RST;
    if (flush)
      return ACT_FLUSH;
    if (up == NoStop)
      return ACT_ADV;
    if (dn == NoStop)
      return ACT_BUBBLE;
    return ACT_HOLD;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] One = 1;
  localparam logic [CNT_W-1:0] Max = '1;

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && count != Max)
      count <= count + One;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - multi-lane pipeline stage register with flush/bubble/hold
// Optional perf counters are compiled in with macro PIPE_PERF_EN.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int STAGE   = 1,
  parameter int STALL_W = 6,
  parameter int LANES   = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*ADDR_W-1:0]   in_pc,
  input  logic [LANES*DATA_W-1:0]   in_inst,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES*ADDR_W-1:0]   out_pc,
  output logic [LANES*DATA_W-1:0]   out_inst,
  output logic                      bubble
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]          perf_stall,
  output logic [CNT_W-1:0]          perf_bubble,
  output logic [CNT_W-1:0]          perf_flush
`endif
);

  if (STAGE + 1 >= STALL_W) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
  end
  if (ADDR_W > ZeroWordW || DATA_W > ZeroWordW) begin : g_bad_width
    $error("pipe_stage_reg: ADDR_W/DATA_W exceed ZeroWordW");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("pipe_stage_reg: CNT_W must be at least 1");
  end

  logic up;
  logic dn;
  act_e act;

  assign up  = stall[STAGE];
  assign dn  = stall[STAGE+1];
  assign act = decode_action(rst, flush, up, dn);

  // Only two bits of the shared stall vector belong to this stage.
  logic unused_stall;
  assign unused_stall = ^stall;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] inst_q;

    always_ff @(posedge clk) begin
      unique case (act)
        ACT_RST, ACT_FLUSH, ACT_BUBBLE: begin
          valid_q <= 1'b0;
          pc_q    <= ZeroWord[ADDR_W-1:0];
          inst_q  <= ZeroWord[DATA_W-1:0];
        end
        ACT_HOLD: begin
          valid_q <= valid_q;
          pc_q    <= pc_q;
          inst_q  <= inst_q;
        end
        default: begin
          // Invalid lanes carry zeros so stale fields never leak downstream.
          valid_q <= in_valid[l];
          pc_q    <= in_valid[l] ? in_pc[l*ADDR_W +: ADDR_W] : ZeroWord[ADDR_W-1:0];
          inst_q  <= in_valid[l] ? in_inst[l*DATA_W +: DATA_W] : ZeroWord[DATA_W-1:0];
        end
      endcase
    end

    assign out_valid[l]                 = valid_q;
    assign out_pc[l*ADDR_W +: ADDR_W]   = pc_q;
    assign out_inst[l*DATA_W +: DATA_W] = inst_q;
  end

  always_ff @(posedge clk) begin
    bubble <= (act == ACT_BUBBLE);
  end

  illegal_stall_combo: assert property (@(posedge clk) disable iff (rst)
    !(up == NoStop && dn == Stop));

`ifdef PIPE_PERF_EN
  sat_counter #(.CNT_W(CNT_W)) u_perf_stall (
    .clk   (clk),
    .clr   (rst),
    .inc   (act == ACT_HOLD),
    .count (perf_stall)
  );

  sat_counter #(.CNT_W(CNT_W)) u_perf_bubble (
    .clk   (clk),
    .clr   (rst),
    .inc   (act == ACT_BUBBLE),
    .count (perf_bubble)
  );

  sat_counter #(.CNT_W(CNT_W)) u_perf_flush (
    .clk   (clk),
    .clr   (rst),
    .inc   (act == ACT_FLUSH),
    .count (perf_flush)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table, corner sequences and random model check for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [63:0] in_pc = '0;
  logic [63:0] in_inst = '0;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_inst;
  logic        bubble;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0] perf_bubble;
  logic [CNT_W-1:0] perf_flush;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .STAGE(1), .STALL_W(6), .LANES(2), .ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .bubble    (bubble)
`ifdef PIPE_PERF_EN
    ,
    .perf_stall  (perf_stall),
    .perf_bubble (perf_bubble),
    .perf_flush  (perf_flush)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the stage should present after each edge.
  logic [1:0]  m_valid;
  logic [31:0] m_pc [2];
  logic [31:0] m_inst [2];
  logic        m_bubble;
  int          m_cnt_stall, m_cnt_bubble, m_cnt_flush;

  function automatic int sat_inc(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic model_edge(input logic r, input logic f, input logic [5:0] s,
                            input logic [1:0] v, input logic [63:0] pc, input logic [63:0] inst);
    if (r) begin
      m_valid = '0; m_bubble = 1'b0;
      for (int l = 0; l < 2; l++) begin m_pc[l] = '0; m_inst[l] = '0; end
      m_cnt_stall = 0; m_cnt_bubble = 0; m_cnt_flush = 0;
    end else if (f || (s[1] && !s[2])) begin
      m_valid = '0;
      for (int l = 0; l < 2; l++) begin m_pc[l] = '0; m_inst[l] = '0; end
      m_bubble = !f;
      if (f) m_cnt_flush = sat_inc(m_cnt_flush);
      else   m_cnt_bubble = sat_inc(m_cnt_bubble);
    end else if (s[1]) begin
      m_bubble = 1'b0;
      m_cnt_stall = sat_inc(m_cnt_stall);
    end else begin
      m_bubble = 1'b0;
      m_valid = v;
      for (int l = 0; l < 2; l++) begin
        m_pc[l]   = v[l] ? pc[l*32 +: 32] : 32'h0;
        m_inst[l] = v[l] ? inst[l*32 +: 32] : 32'h0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic [5:0] s,
                      input logic [1:0] v, input logic [63:0] pc, input logic [63:0] inst);
    @(negedge clk);
    rst = r; flush = f; stall = s; in_valid = v; in_pc = pc; in_inst = inst;
    model_edge(r, f, s, v, pc, inst);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " valid"},  {62'h0, out_valid}, {62'h0, m_valid});
    chk({tag, " pc"},     out_pc,   {m_pc[1], m_pc[0]});
    chk({tag, " inst"},   out_inst, {m_inst[1], m_inst[0]});
    chk({tag, " bubble"}, {63'h0, bubble}, {63'h0, m_bubble});
`ifdef PIPE_PERF_EN
    chk({tag, " perf_stall"},  {60'h0, perf_stall},  64'(m_cnt_stall));
    chk({tag, " perf_bubble"}, {60'h0, perf_bubble}, 64'(m_cnt_bubble));
    chk({tag, " perf_flush"},  {60'h0, perf_flush},  64'(m_cnt_flush));
`endif
  endtask

  typedef struct {
    logic        r;
    logic        f;
    logic [5:0]  s;
    logic [1:0]  v;
    logic [63:0] pc;
    logic [63:0] inst;
    logic [1:0]  ev;
    logic [63:0] epc;
    logic [63:0] einst;
    logic        eb;
    int          eps;
    int          epb;
    int          epf;
  } vec_t;

  localparam logic [5:0] SADV  = 6'b000000;
  localparam logic [5:0] SHOLD = 6'b000110;
  localparam logic [5:0] SBUB  = 6'b000010;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, SADV, 2'b11, 64'h00000104_00000100, 64'h24010002_24010001,
                2'b00, 64'h0, 64'h0, 1'b0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, SADV, 2'b01, 64'h00000204_00000200, 64'h8c220004_24010001,
                2'b01, 64'h00000000_00000200, 64'h00000000_24010001, 1'b0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, SADV, 2'b11, 64'h0000030c_00000308, 64'h00000011_00000022,
                2'b11, 64'h0000030c_00000308, 64'h00000011_00000022, 1'b0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, SHOLD, 2'b00, 64'h00000404_00000400, 64'h0,
                2'b11, 64'h0000030c_00000308, 64'h00000011_00000022, 1'b0, 1, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, SHOLD, 2'b11, 64'h00000414_00000410, 64'h99,
                2'b11, 64'h0000030c_00000308, 64'h00000011_00000022, 1'b0, 2, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, SHOLD, 2'b10, 64'h00000424_00000420, 64'h98,
                2'b11, 64'h0000030c_00000308, 64'h00000011_00000022, 1'b0, 3, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, SBUB, 2'b11, 64'h00000434_00000430, 64'h97,
                2'b00, 64'h0, 64'h0, 1'b1, 3, 1, 0};
    tbl[7]  = '{1'b0, 1'b0, SADV, 2'b10, 64'h00000504_00000500, 64'h00000033_00000044,
                2'b10, 64'h00000504_00000000, 64'h00000033_00000000, 1'b0, 3, 1, 0};
    tbl[8]  = '{1'b1 ^ 1'b1, 1'b1, SHOLD, 2'b11, 64'h00000514_00000510, 64'h1,
                2'b00, 64'h0, 64'h0, 1'b0, 3, 1, 1};
    tbl[9]  = '{1'b0, 1'b0, SADV, 2'b11, 64'h00000604_00000600, 64'h00000055_00000066,
                2'b11, 64'h00000604_00000600, 64'h00000055_00000066, 1'b0, 3, 1, 1};
    tbl[10] = '{1'b1, 1'b0, SHOLD, 2'b11, 64'h00000614_00000610, 64'h2,
                2'b00, 64'h0, 64'h0, 1'b0, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, SADV, 2'b11, 64'h00000704_00000700, 64'h00000077_00000088,
                2'b11, 64'h00000704_00000700, 64'h00000077_00000088, 1'b0, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b0, SBUB, 2'b11, 64'h00000714_00000710, 64'h3,
                2'b00, 64'h0, 64'h0, 1'b1, 0, 1, 0};
    tbl[13] = '{1'b0, 1'b0, SHOLD, 2'b11, 64'h00000724_00000720, 64'h4,
                2'b00, 64'h0, 64'h0, 1'b0, 1, 1, 0};
    tbl[14] = '{1'b0, 1'b1, SADV, 2'b11, 64'h00000734_00000730, 64'h5,
                2'b00, 64'h0, 64'h0, 1'b0, 1, 1, 1};
    tbl[15] = '{1'b0, 1'b0, 6'b111001, 2'b11, 64'h00000804_00000800, 64'h000000aa_000000bb,
                2'b11, 64'h00000804_00000800, 64'h000000aa_000000bb, 1'b0, 1, 1, 1};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].v, tbl[i].pc, tbl[i].inst);
      chk($sformatf("vec%0d valid", i),  {62'h0, out_valid}, {62'h0, tbl[i].ev});
      chk($sformatf("vec%0d pc", i),     out_pc,   tbl[i].epc);
      chk($sformatf("vec%0d inst", i),   out_inst, tbl[i].einst);
      chk($sformatf("vec%0d bubble", i), {63'h0, bubble}, {63'h0, tbl[i].eb});
`ifdef PIPE_PERF_EN
      chk($sformatf("vec%0d perf_stall", i),  {60'h0, perf_stall},  64'(tbl[i].eps));
      chk($sformatf("vec%0d perf_bubble", i), {60'h0, perf_bubble}, 64'(tbl[i].epb));
      chk($sformatf("vec%0d perf_flush", i),  {60'h0, perf_flush},  64'(tbl[i].epf));
`endif
    end

    // Bubble pulse lasts exactly one cycle when followed by advance.
    step(1'b0, 1'b0, SBUB, 2'b11, 64'h1, 64'h2);
    chk("bubble pulse hi", {63'h0, bubble}, 64'h1);
    step(1'b0, 1'b0, SADV, 2'b11, 64'h00000904_00000900, 64'h00000011_00000012);
    chk("bubble pulse lo", {63'h0, bubble}, 64'h0);
    chk_model("after bubble adv");

    // Twenty holds: counter must saturate rather than wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, SHOLD, 2'($urandom), 64'({$urandom, $urandom}), 64'({$urandom, $urandom}));
    end
    chk_model("long hold");
`ifdef PIPE_PERF_EN
    chk("perf_stall saturated", {60'h0, perf_stall}, 64'hF);
`endif

    // Randomized traffic with legal stall combinations only.
    for (int i = 0; i < 300; i++) begin
      logic [5:0] s;
      logic r, f;
      s = 6'($urandom);
      if (!s[1]) s[2] = 1'b0;
      r = ($urandom_range(0, 19) == 0);
      f = ($urandom_range(0, 7) == 0);
      step(r, f, s, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      chk_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
